// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a registered-read data memory.
// One transaction at a time: IDLE (grant) -> ISSUE (drive memory) -> CAPTURE
// (read data valid) -> registered response to the winning requester.
module dmem_arbiter #(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_valid,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [31:0]   r0_wdata,
  input  logic          r1_valid,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [31:0]   r1_wdata,
  output logic          r0_ready,
  output logic          r1_ready,
  output logic          r0_rsp_valid,
  output logic          r1_rsp_valid,
  output logic [31:0]   r0_rsp_rdata,
  output logic [31:0]   r1_rsp_rdata,
  output logic          r0_rsp_err,
  output logic          r1_rsp_err,
  output logic          mem_write_enable,
  output logic [AW-1:0] mem_read_address,
  output logic [AW-1:0] mem_write_address,
  output logic [31:0]   mem_data_in,
  input  logic [31:0]   mem_data_out
);

  // One extra bit so the range check never truncates DEPTH or the address.
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_last_grant;
  logic          r_id;
  logic          r_we;
  logic          r_oor;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;

  logic          w_any;
  logic          w_grant;
  logic          w_accept;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [31:0]   w_sel_wdata;

  // Grant selection: a lone requester wins; under contention the one not served last wins.
  always_comb begin
    w_any   = r0_valid | r1_valid;
    w_grant = 1'b0;
    if (r0_valid && r1_valid) begin
      w_grant = ~r_last_grant;
    end else if (r1_valid) begin
      w_grant = 1'b1;
    end
    w_accept    = (r_state == S_IDLE) && w_any;
    w_sel_we    = w_grant ? r1_we    : r0_we;
    w_sel_addr  = w_grant ? r1_addr  : r0_addr;
    w_sel_wdata = w_grant ? r1_wdata : r0_wdata;
  end

  assign r0_ready = w_accept & ~w_grant;
  assign r1_ready = w_accept &  w_grant;

  // State register plus capture of the accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_oor        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_id         <= w_grant;
        r_last_grant <= w_grant;
        r_we         <= w_sel_we;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
        r_oor        <= ({1'b0, w_sel_addr} >= DEPTH_X);
      end
    end
  end

  // Next state and the ISSUE-only write strobe; decoding from state lets reset kill it instantly.
  always_comb begin
    w_state_next     = r_state;
    mem_write_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        mem_write_enable = r_we & ~r_oor;
        w_state_next     = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign mem_read_address  = r_addr;
  assign mem_write_address = r_addr;
  assign mem_data_in       = r_wdata;

  // Per-requester response registers; only the captured requester's set is touched.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic        w_hit;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    assign w_hit = (r_state == S_CAPTURE) && (r_id == 1'(gi));

    // Valid pulses for one cycle; data and error hold until this requester's next response.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rsp_valid <= 1'b0;
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= '0;
      end else begin
        r_rsp_valid <= w_hit;
        if (w_hit) begin
          r_rsp_err   <= r_oor;
          r_rsp_rdata <= r_oor ? 32'h0 : mem_data_out;
        end
      end
    end
  end

  assign r0_rsp_valid = g_rsp[0].r_rsp_valid;
  assign r0_rsp_err   = g_rsp[0].r_rsp_err;
  assign r0_rsp_rdata = g_rsp[0].r_rsp_rdata;
  assign r1_rsp_valid = g_rsp[1].r_rsp_valid;
  assign r1_rsp_err   = g_rsp[1].r_rsp_err;
  assign r1_rsp_rdata = g_rsp[1].r_rsp_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a registered-read memory model sits on the
// memory ports, accepted requests push expected responses computed from a
// shadow memory, and an independent monitor pops and compares responses.
module tb_dmem_arbiter;
  localparam int DEPTH = 1024;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r0_valid = 1'b0, r1_valid = 1'b0, r0_we = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [31:0] r0_wdata = '0, r1_wdata = '0;
  logic r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err;
  logic [31:0] r0_rsp_rdata, r1_rsp_rdata;
  logic mem_write_enable;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_rsp_valid(r0_rsp_valid), .r1_rsp_valid(r1_rsp_valid),
    .r0_rsp_rdata(r0_rsp_rdata), .r1_rsp_rdata(r1_rsp_rdata),
    .r0_rsp_err(r0_rsp_err), .r1_rsp_err(r1_rsp_err),
    .mem_write_enable(mem_write_enable),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // ---------------- memory model (registered read, read-before-write) ----------------
  logic [31:0] mem      [DEPTH];
  logic [31:0] init_val [DEPTH];
  bit          mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val[i];
      mem_init_done <= 1'b1;
    end else begin
      if (mem_write_enable && mem_write_address < DEPTH)
        mem[mem_write_address[9:0]] <= mem_data_in;
      mem_data_out <= (mem_read_address < DEPTH) ? mem[mem_read_address[9:0]] : 32'h0;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;

  logic [31:0] ref_mem [DEPTH];
  rsp_t q0[$];
  rsp_t q1[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          pend      [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];

  int          last_acc = -100;
  int          last_grant = 1;
  logic [31:0] cap_addr = '0, cap_wdata = '0, old_val = '0;
  logic        cap_we = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Acceptance tracker: checks grant rules and memory port driving, pushes expected responses.
  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    logic       issue_cyc;
    int         id;
    rsp_t       e;
    if (!rst_n) begin
      // In-flight write dropped before its memory cycle: undo it in the shadow memory.
      if (last_acc >= 0 && cyc <= last_acc + 1 && cap_we && cap_addr < DEPTH)
        ref_mem[cap_addr[9:0]] = old_val;
      last_acc = -100; last_grant = 1;
      cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
      q0.delete(); q1.delete();
    end else begin
      exp_rdy = 2'b00;
      if ((cyc - last_acc) >= 3 && (r0_valid || r1_valid)) begin
        if (r0_valid && r1_valid) exp_rdy = (last_grant == 1) ? 2'b01 : 2'b10;
        else exp_rdy = {r1_valid, r0_valid};
      end
      chk("ready", {62'd0, r1_ready, r0_ready}, {62'd0, exp_rdy});
      chk("mem_read_address", mem_read_address, cap_addr);
      chk("mem_write_address", mem_write_address, cap_addr);
      issue_cyc = (cyc == last_acc + 1);
      chk("mem_write_enable", mem_write_enable, issue_cyc && cap_we && cap_addr < DEPTH);
      if (issue_cyc) chk("mem_data_in", mem_data_in, cap_wdata);
      if (r0_ready || r1_ready) begin
        id      = r1_ready ? 1 : 0;
        e.err   = (req_addr[id] >= DEPTH);
        e.rdata = e.err ? 32'h0 : ref_mem[req_addr[id][9:0]];
        e.due   = cyc + 3;
        old_val = e.rdata;
        if (req_we[id] && !e.err) ref_mem[req_addr[id][9:0]] = req_wdata[id];
        if (id == 0) q0.push_back(e); else q1.push_back(e);
        cap_addr = req_addr[id]; cap_wdata = req_wdata[id]; cap_we = req_we[id];
        last_acc = cyc; last_grant = id; pend[id] = 1'b0;
      end
    end
  end

  // ---------------- response monitor ----------------
  logic [31:0] hold_rd  [2];
  logic        hold_err [2];

  task automatic check_rsp(input int id, input logic v, input logic [31:0] rd, input logic er);
    rsp_t e;
    if (v) begin
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        n_checks++; n_fail++;
        $display("FAIL rsp%0d_unexpected: got rsp_valid 1, required 0 (cycle %0d)", id, cyc);
      end else begin
        if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("rsp%0d_rdata", id), rd, e.rdata);
        chk($sformatf("rsp%0d_err", id), er, e.err);
        chk($sformatf("rsp%0d_latency", id), cyc, e.due);
        hold_rd[id] = e.rdata; hold_err[id] = e.err;
        $display("rsp r%0d cycle %0d rdata=%08h err=%0d", id, cyc, rd, er);
      end
    end else begin
      chk($sformatf("rsp%0d_rdata_hold", id), rd, hold_rd[id]);
      chk($sformatf("rsp%0d_err_hold", id), er, hold_err[id]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin hold_rd[i] = '0; hold_err[i] = 1'b0; end
    end else begin
      check_rsp(0, r0_rsp_valid, r0_rsp_rdata, r0_rsp_err);
      check_rsp(1, r1_rsp_valid, r1_rsp_rdata, r1_rsp_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive();
    r0_valid = pend[0]; r0_we = req_we[0]; r0_addr = req_addr[0]; r0_wdata = req_wdata[0];
    r1_valid = pend[1]; r1_we = req_we[1]; r1_addr = req_addr[1]; r1_wdata = req_wdata[1];
  endtask

  task automatic new_req(input int i, input bit rd_only);
    int r;
    r = $urandom_range(0, 9);
    pend[i]   = 1'b1;
    req_we[i] = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
    if (r < 6)      req_addr[i] = $urandom_range(0, 15);
    else if (r < 8) req_addr[i] = $urandom_range(DEPTH - 4, DEPTH + 3);
    else if (r < 9) req_addr[i] = 32'h8000_0000 | $urandom_range(0, 15);
    else            req_addr[i] = $urandom_range(0, DEPTH - 1);
    req_wdata[i] = $urandom;
  endtask

  task automatic step(input int pct, input bit rd_only);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      if (!pend[i] && $urandom_range(1, 100) <= pct) new_req(i, rd_only);
    drive();
  endtask

  task automatic wait_accept(input int id);
    for (int k = 0; k < 20 && pend[id]; k++) step(0, 1'b0);
    if (pend[id]) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: r%0d still pending, required accepted", id);
      pend[id] = 1'b0; drive();
    end
  endtask

  task automatic issue(input int id, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    pend[id] = 1'b1; req_we[id] = we; req_addr[id] = addr; req_wdata[id] = wdata;
    drive();
    wait_accept(id);
    repeat (4) step(0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (pend[0] || pend[1]); k++) step(0, 1'b0);
    if (pend[0] || pend[1]) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: pending %0d%0d, required 00", pend[1], pend[0]);
      pend[0] = 1'b0; pend[1] = 1'b0; drive();
    end
    repeat (5) step(0, 1'b0);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      init_val[i] = v; ref_mem[i] = v;
    end
    init_val[13] = 32'd9; ref_mem[13] = 32'd9;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    drive();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_r0_ready", r0_ready, 1'b0);
    chk("reset_r1_ready", r1_ready, 1'b0);
    chk("reset_r0_rsp_valid", r0_rsp_valid, 1'b0);
    chk("reset_r1_rsp_valid", r1_rsp_valid, 1'b0);
    chk("reset_r0_rsp_rdata", r0_rsp_rdata, 32'h0);
    chk("reset_r1_rsp_rdata", r1_rsp_rdata, 32'h0);
    chk("reset_r0_rsp_err", r0_rsp_err, 1'b0);
    chk("reset_r1_rsp_err", r1_rsp_err, 1'b0);
    chk("reset_mem_we", mem_write_enable, 1'b0);
    chk("reset_mem_raddr", mem_read_address, 32'h0);
    chk("reset_mem_waddr", mem_write_address, 32'h0);
    chk("reset_mem_din", mem_data_in, 32'h0);
    rst_n = 1'b1;

    // Basic read, write returning pre-write data, read back
    issue(0, 1'b0, 32'd13, 32'h0);
    issue(1, 1'b1, 32'd13, 32'h55);
    issue(0, 1'b0, 32'd13, 32'h0);

    // Continuous contention with reads: strict alternation
    repeat (24) step(100, 1'b1);
    drain();

    // Range boundary
    issue(0, 1'b1, 32'd1024, 32'hFFFF);
    issue(0, 1'b1, 32'd1023, 32'h1234_5678);
    issue(0, 1'b0, 32'd1023, 32'h0);
    issue(1, 1'b0, 32'hFFFF_FFFF, 32'h0);

    // Reset asserted during ISSUE of a write
    @(posedge clk); #1;
    pend[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'd5; req_wdata[1] = 32'hDEAD_BEEF;
    drive();
    wait_accept(1);
    #1;
    chk("issue_write_enable", mem_write_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_write_enable", mem_write_enable, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    pend[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'd5; req_wdata[0] = '0;
    pend[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'd7; req_wdata[1] = '0;
    drive();
    rst_n = 1'b1;
    drain();

    // Randomized mixed traffic
    repeat (600) step(60, 1'b0);
    drain();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-port-per-direction data memory between requester 0 (CPU load/store unit) and requester 1 (program/data loader or debug port).
- The memory has a registered read: data_out updates one clock after read_address is sampled, and reads return the old contents on a same-address write.
- The arbiter accepts one transaction at a time, sequences the memory ports, range-checks addresses, and returns a registered response to the winning requester.

Parameters:
- DEPTH, 1024, number of 32-bit words in the memory; valid word addresses are 0..DEPTH-1.
- AW, 32, address width of request and memory address ports.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- r0_valid, r1_valid  in  1  request present; must stay high, with fields stable, until the matching ready
- r0_we, r1_we  in  1  1 = write, 0 = read
- r0_addr, r1_addr  in  AW  word address
- r0_wdata, r1_wdata  in  32  write data
- r0_ready, r1_ready  out  1  combinational accept pulse, one cycle
- r0_rsp_valid, r1_rsp_valid  out  1  registered response pulse, one cycle
- r0_rsp_rdata, r1_rsp_rdata  out  32  read data, or pre-write data for writes; 0 on error
- r0_rsp_err, r1_rsp_err  out  1  address out of range; qualified by rsp_valid
- mem_write_enable  out  1  to memory write_enable
- mem_read_address, mem_write_address  out  AW  to memory address ports
- mem_data_in  out  32  to memory data_in
- mem_data_out  in  32  from memory data_out

Behaviour:
- Reset state:
  - FSM is IDLE; every registered output is 0.
  - Captured addr, wdata, we and requester id are 0; mem_write_enable is 0.
  - last_grant = 1, so requester 0 wins the first contended arbitration.
- FSM states: IDLE -> ISSUE -> CAPTURE -> IDLE. Throughput is one transaction per 3 cycles.
- IDLE (cycle T):
  - If any valid is high, grant: the single valid requester, or if both, the one != last_grant.
  - Assert the winner's ready combinationally in T; the loser's ready stays 0.
  - At posedge, capture id, we, addr and wdata; set last_grant = id; set oor = (addr >= DEPTH); go to ISSUE.
  - No ready is asserted in any state other than IDLE.
- ISSUE (T+1):
  - mem_read_address and mem_write_address = captured addr; mem_data_in = captured wdata.
  - mem_write_enable = we & ~oor, decoded combinationally from state, so it is high only in this cycle.
  - The memory samples at the end of T+1. Go to CAPTURE.
- CAPTURE (T+2):
  - mem_data_out now holds the read result (old contents for a write).
  - At posedge, set rsp_valid of the captured id; rsp_rdata = oor ? 0 : mem_data_out; rsp_err = oor. Go to IDLE.
- Response (T+3):
  - The selected rsp_valid is high for exactly one cycle; rdata and err hold until the next response to that requester.
  - The other requester's rsp outputs are unchanged.
  - A new grant may occur in T+3.
- Memory address outputs hold the captured addr outside ISSUE; mem_write_enable is 0 outside ISSUE.
- Out of range (addr >= DEPTH, including upper AW bits set):
  - No memory write occurs.
  - The response carries the normal 3-cycle latency, with err = 1 and rdata = 0.
- Address DEPTH-1 is in range. No wrap-around or address truncation.
- A requester that keeps valid high after ready is treated as issuing a new request; under contention the requesters alternate strictly.
- Reset mid-operation:
  - Asserting rst_n low forces IDLE and clears mem_write_enable immediately, with no clock needed.
  - The in-flight transaction is dropped: no rsp_valid, and no write if reset asserts before the ISSUE posedge.
  - Memory contents are not touched.

Test Plan:
- Release reset, r0 read addr 13 (memory preloaded with 9) -> r0_ready in T, mem_read_address = 13 in T+1, r0_rsp_valid in T+3 with rdata = 9, err = 0; r1 outputs stay 0.
- r1 write addr 13, data 0x55 -> mem_write_enable high only in T+1, r1_rsp_rdata = 9 (pre-write) at T+3; a following r0 read of 13 returns 0x55.
- r0 and r1 both valid continuously with reads -> grants at T, T+3, T+6, T+9 go 0, 1, 0, 1; each requester sees one rsp_valid per 6 cycles.
- r0 write addr 1024, data 0xFFFF -> mem_write_enable never high, r0_rsp_err = 1, rdata = 0 at T+3; addr 1023 write then read succeeds with err = 0.
- Assert rst_n during ISSUE of an r1 write to addr 5 -> mem_write_enable drops within the same cycle, no r1_rsp_valid, addr 5 keeps its old value. After release with both valid, r0 is granted first.
